eth_rx_ring: RTL and testbench
==============================

// Module: eth_rx_ring
// PURPOSE
//  Parametrised Ethernet receive ring for the framing block.
//  - Accepts a byte-wide AXI-Stream from the RGMII MAC, already in the msoc_clk domain.
//  - Applies the destination-MAC filter and stores accepted frames in NBUF circular buffers.
//  - Records each frame length; the host reads buffers over a word-wide port and frees them in order.
//  - Raises eth_irq while frames are pending. Drops on full ring, oversize frame or MAC error.
// PARAMETERS
//  NBUF       8     number of frame buffers; power of 2, 2..16
//  BUF_BYTES  2048  bytes per buffer; power of 2, >=64
//  DATA_W     64    host read width; 32 or 64
// PORTS
//  msoc_clk       in   1      sole clock
//  rst_int_n      in   1      asynchronous active-low reset
//  rx_tdata       in   8      frame byte, first byte = dest MAC MSB
//  rx_tvalid      in   1      byte valid
//  rx_tlast       in   1      last byte of frame (FCS included)
//  rx_tuser       in   1      MAC error flag, sampled with tlast
//  rx_tready      out  1      byte accepted when tvalid&tready
//  mac_address    in   48     station address
//  promiscuous    in   1      accept all frames
//  irq_en         in   1      interrupt enable
//  consume        in   1      pulse: free buffer at firstbuf
//  rd_en          in   1      host read strobe
//  rd_addr        in   log2(NBUF)+log2(BUF_BYTES*8/DATA_W)  {buffer, word}
//  rd_data        out  DATA_W read word, 1-cycle latency
//  rd_len         out  16     length of buffer rd_addr selects, 1-cycle latency
//  firstbuf       out  log2(NBUF)+1  oldest-full pointer, with wrap bit
//  nextbuf        out  log2(NBUF)+1  fill pointer, with wrap bit
//  avail          out  1      nextbuf != firstbuf
//  eth_irq        out  1      registered avail & irq_en
// BEHAVIOUR
//  - Reset: state IDLE; pointers 0; rd_data, rd_len 0; eth_irq 0; rx_tready 1; lengths 0.
//  - FSM: IDLE -> HDR on the first accepted byte; HDR -> BODY after 6 bytes; BODY -> COMMIT on tlast.
//  - FSM: COMMIT -> IDLE after 1 cycle. DROP -> IDLE on the accepted tlast.
//  - rx_tready = 0 only in COMMIT; 1 in every other state.
//  - Ring full: nextbuf-firstbuf == NBUF, (log2(NBUF)+1)-bit arithmetic. A first byte arriving while full goes to DROP.
//  - Byte k is written to buf[nextbuf][k] in the cycle it is accepted. Word layout is little-endian: byte k sits at word k/(DATA_W/8), lane k%(DATA_W/8).
//  - HDR shifts bytes into dest = {dest[39:0], tdata}.
//  - Filter pass = dest[47:24]==24'h01005E | &dest | dest==mac_address | promiscuous.
//  - tlast while still in HDR (frame <6 bytes): drop, return to IDLE.
//  - Byte count reaching BUF_BYTES without tlast: enter DROP; remaining bytes are discarded.
//  - COMMIT: if filter pass and ~tuser, then len[nextbuf] <= bytecount (tlast byte included, 16 bit) and nextbuf++. Otherwise the buffer is reused.
//  - consume while avail: firstbuf++. consume while empty: ignored.
//  - COMMIT and consume in the same cycle: both apply; the count is unchanged.
//  - eth_irq deasserts the cycle after irq_en falls or the last buffer is consumed.
//  - Host reads of a buffer currently being filled return undefined data. No other side effects.
//  - Pointers wrap modulo 2*NBUF; the buffer index is the low log2(NBUF) bits.
// CONFIGURATION
//  ETH_RX_STATS_EN defined:
//    - Adds outputs stat_ok, stat_full, stat_filt, stat_err (32 b each); reset 0.
//    - Saturating counters, +1 per frame outcome:
//      - stat_ok: committed frames.
//      - stat_full: frames dropped on a full ring.
//      - stat_filt: frames failing the filter or shorter than 6 bytes.
//      - stat_err: tuser errors and oversize frames.
//  ETH_RX_STATS_EN undefined: stat ports absent, no counter logic.
// STRUCTURE
//  - eth_rx_pkg: state enum (IDLE, HDR, BODY, COMMIT, DROP), MCAST_OUI=24'h01005E, len_t (16 b), ring pointer width function.
//  - Sub-module eth_rx_bufmem: byte-write / DATA_W-read simple dual-port RAM, NBUF*BUF_BYTES bytes, registered read.
//  - Top level holds the FSM, filter, pointers, length array and optional stats.
// TESTING
//  1. Unicast 64-byte frame, dest==mac_address -> nextbuf 1, avail 1, rd_len 64, bytes read back in order.
//  2. Frame to 01:00:5E:00:00:01 and to FF:FF:FF:FF:FF:FF with promiscuous=0 -> both accepted.
//     Dest 02:00:00:00:00:01 -> dropped; promiscuous=1 -> accepted.
//  3. NBUF+1 back-to-back frames, no consume -> first NBUF stored, last dropped, nextbuf-firstbuf==NBUF.
//     One consume -> next frame accepted.
//  4. Frame with tuser=1 on tlast -> not committed; next good frame lands in the same buffer index.
//  5. COMMIT coincident with consume, count 3 -> count stays 3. irq_en toggled -> eth_irq follows 1 cycle later.
//  6. rst_int_n asserted mid-frame (byte 30) -> all outputs at reset values. Next frame lands in buffer 0.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive ring.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      BODY,
      COMMIT,
      DROP
   } state_t;

   localparam logic [23:0] MCAST_OUI = 24'h01005E;
   localparam int          HDR_BYTES = 6;

   typedef logic [15:0] len_t;

   // Ring pointers carry one extra wrap bit above the buffer index.
   function automatic int ptr_w(input int nbuf);
      return $clog2(nbuf) + 1;
   endfunction

endpackage

// File: rtl/eth_rx_bufmem.sv
// Frame storage: byte-wide write port, DATA_W-wide little-endian read port.
// Latency: write lands at the clock edge; read data is registered, 1 cycle after rd_en.
// Backpressure: none, both ports accept every cycle.
module eth_rx_bufmem import eth_rx_pkg::*; #(
   parameter int NBUF      = 8,
   parameter int BUF_BYTES = 2048,
   parameter int DATA_W    = 64
) (
   input  logic                                                  clk,
   input  logic                                                  rst_n,
   input  logic                                                  wr_en,
   input  logic [$clog2(NBUF)-1:0]                               wr_buf,
   input  logic [$clog2(BUF_BYTES)-1:0]                          wr_byte,
   input  logic [7:0]                                            wr_data,
   input  logic                                                  rd_en,
   input  logic [$clog2(NBUF)+$clog2(BUF_BYTES*8/DATA_W)-1:0]    rd_addr,
   output logic [DATA_W-1:0]                                     rd_data
);

   localparam int LB    = $clog2(DATA_W/8);
   localparam int OW    = $clog2(BUF_BYTES);
   localparam int AW    = $clog2(NBUF) + $clog2(BUF_BYTES*8/DATA_W);
   localparam int NWORD = NBUF * BUF_BYTES * 8 / DATA_W;

   logic [DATA_W-1:0] mem [NWORD];
   logic [AW-1:0]     waddr;
   logic [LB-1:0]     wlane;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   assign waddr   = {wr_buf, wr_byte[OW-1:LB]};
   assign wlane   = wr_byte[LB-1:0];
   assign rd_data = rd_data_q;

   // Byte lane write: byte k of a buffer goes to word k/(DATA_W/8), lane k%(DATA_W/8).
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[waddr][{wlane, 3'b000} +: 8] <= wr_data;
      end
   end

   // Hold the last read word until the next strobe.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   // Registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

endmodule

// File: rtl/eth_rx_ring.sv
// Ethernet receive ring: MAC filter, NBUF frame buffers, length table, host read/free, irq.
// Latency: byte stored the cycle it is accepted; frame visible 1 cycle after tlast; reads 1 cycle.
// Backpressure: rx_tready drops only for the single COMMIT cycle. ETH_RX_STATS_EN adds outcome counters.
module eth_rx_ring import eth_rx_pkg::*; #(
   parameter int NBUF      = 8,
   parameter int BUF_BYTES = 2048,
   parameter int DATA_W    = 64
) (
   input  logic                                                  msoc_clk,
   input  logic                                                  rst_int_n,
   input  logic [7:0]                                            rx_tdata,
   input  logic                                                  rx_tvalid,
   input  logic                                                  rx_tlast,
   input  logic                                                  rx_tuser,
   output logic                                                  rx_tready,
   input  logic [47:0]                                           mac_address,
   input  logic                                                  promiscuous,
   input  logic                                                  irq_en,
   input  logic                                                  consume,
   input  logic                                                  rd_en,
   input  logic [$clog2(NBUF)+$clog2(BUF_BYTES*8/DATA_W)-1:0]    rd_addr,
   output logic [DATA_W-1:0]                                     rd_data,
   output logic [15:0]                                           rd_len,
   output logic [$clog2(NBUF):0]                                 firstbuf,
   output logic [$clog2(NBUF):0]                                 nextbuf,
   output logic                                                  avail,
   output logic                                                  eth_irq
`ifdef ETH_RX_STATS_EN
   ,
   output logic [31:0]                                           stat_ok,
   output logic [31:0]                                           stat_full,
   output logic [31:0]                                           stat_filt,
   output logic [31:0]                                           stat_err
`endif
);

   localparam int BW = $clog2(NBUF);
   localparam int PW = ptr_w(NBUF);
   localparam int OW = $clog2(BUF_BYTES);
   localparam int CW = OW + 1;
   localparam int WW = $clog2(BUF_BYTES*8/DATA_W);
   localparam int AW = BW + WW;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d, cnt_nxt;
   logic [47:0]    dest_q, dest_d;
   logic           tuser_q, tuser_d;
   logic [PW-1:0]  nextbuf_q, nextbuf_d;
   logic [PW-1:0]  firstbuf_q, firstbuf_d;
   logic [PW-1:0]  fill_cnt;
   len_t           len_q [NBUF];
   len_t           len_d [NBUF];
   len_t           rd_len_q, rd_len_d;
   logic           eth_irq_q, eth_irq_d;
   logic           accept, full, filt_pass, commit_ok, do_consume, wr_en;
   logic [BW-1:0]  rd_buf;

   assign rx_tready  = (state_q != COMMIT);
   assign accept     = rx_tvalid & rx_tready;
   assign cnt_nxt    = cnt_q + 1'b1;
   assign fill_cnt   = nextbuf_q - firstbuf_q;
   assign full       = (fill_cnt == PW'(NBUF));
   assign avail      = (nextbuf_q != firstbuf_q);
   assign filt_pass  = (dest_q[47:24] == MCAST_OUI) | (&dest_q) |
                       (dest_q == mac_address) | promiscuous;
   assign commit_ok  = (state_q == COMMIT) & filt_pass & ~tuser_q;
   assign do_consume = consume & avail;
   assign rd_buf     = rd_addr[AW-1:WW];

   assign firstbuf = firstbuf_q;
   assign nextbuf  = nextbuf_q;
   assign rd_len   = rd_len_q;
   assign eth_irq  = eth_irq_q;

   // Frame FSM: header capture, body store, commit/drop decisions.
   // cnt_q is always 0 in IDLE, so it doubles as the write offset of the next byte.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dest_d  = dest_q;
      tuser_d = tuser_q;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (full) begin
                  // Oldest frame still occupies the fill slot: never write it.
                  if (!rx_tlast) state_d = DROP;
               end else begin
                  wr_en  = 1'b1;
                  dest_d = {dest_q[39:0], rx_tdata};
                  if (!rx_tlast) begin
                     cnt_d   = cnt_nxt;
                     state_d = HDR;
                  end
               end
            end
         end
         HDR: begin
            if (accept) begin
               wr_en  = 1'b1;
               dest_d = {dest_q[39:0], rx_tdata};
               cnt_d  = cnt_nxt;
               if (rx_tlast) begin
                  if (cnt_nxt < CW'(HDR_BYTES)) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = COMMIT;
                     tuser_d = rx_tuser;
                  end
               end else if (cnt_nxt == CW'(HDR_BYTES)) begin
                  state_d = BODY;
               end
            end
         end
         BODY: begin
            if (accept) begin
               wr_en = 1'b1;
               cnt_d = cnt_nxt;
               if (rx_tlast) begin
                  state_d = COMMIT;
                  tuser_d = rx_tuser;
               end else if (cnt_nxt == CW'(BUF_BYTES)) begin
                  state_d = DROP;
               end
            end
         end
         COMMIT: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         DROP: begin
            if (accept && rx_tlast) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Ring pointers, length table, read-side length and interrupt.
   always_comb begin
      nextbuf_d  = nextbuf_q;
      firstbuf_d = firstbuf_q;
      for (int i = 0; i < NBUF; i++) len_d[i] = len_q[i];
      if (commit_ok) begin
         len_d[nextbuf_q[BW-1:0]] = len_t'(cnt_q);
         nextbuf_d                = nextbuf_q + 1'b1;
      end
      if (do_consume) begin
         firstbuf_d = firstbuf_q + 1'b1;
      end
      rd_len_d  = rd_en ? len_q[rd_buf] : rd_len_q;
      eth_irq_d = avail & irq_en;
   end

   // State registers.
   always_ff @(posedge msoc_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dest_q     <= '0;
         tuser_q    <= 1'b0;
         nextbuf_q  <= '0;
         firstbuf_q <= '0;
         rd_len_q   <= '0;
         eth_irq_q  <= 1'b0;
         for (int i = 0; i < NBUF; i++) len_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dest_q     <= dest_d;
         tuser_q    <= tuser_d;
         nextbuf_q  <= nextbuf_d;
         firstbuf_q <= firstbuf_d;
         rd_len_q   <= rd_len_d;
         eth_irq_q  <= eth_irq_d;
         for (int i = 0; i < NBUF; i++) len_q[i] <= len_d[i];
      end
   end

   eth_rx_bufmem #(
      .NBUF      (NBUF),
      .BUF_BYTES (BUF_BYTES),
      .DATA_W    (DATA_W)
   ) u_bufmem (
      .clk     (msoc_clk),
      .rst_n   (rst_int_n),
      .wr_en   (wr_en),
      .wr_buf  (nextbuf_q[BW-1:0]),
      .wr_byte (cnt_q[OW-1:0]),
      .wr_data (rx_tdata),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

`ifdef ETH_RX_STATS_EN
   // Outcome counters: [0] ok, [1] full, [2] filtered/runt, [3] error/oversize.
   logic [3:0]  ev;
   logic [31:0] stat_q [4];
   logic [31:0] stat_d [4];

   // One event per frame outcome; tuser error wins over a filter miss.
   always_comb begin
      ev    = '0;
      ev[0] = commit_ok;
      ev[1] = (state_q == IDLE) & accept & full;
      ev[2] = ((state_q == COMMIT) & ~tuser_q & ~filt_pass) |
              ((state_q == IDLE) & accept & ~full & rx_tlast) |
              ((state_q == HDR) & accept & rx_tlast & (cnt_nxt < CW'(HDR_BYTES)));
      ev[3] = ((state_q == COMMIT) & tuser_q) |
              ((state_q == BODY) & accept & ~rx_tlast & (cnt_nxt == CW'(BUF_BYTES)));
      for (int i = 0; i < 4; i++) begin
         stat_d[i] = stat_q[i];
         if (ev[i] && (stat_q[i] != '1)) stat_d[i] = stat_q[i] + 1'b1;
      end
   end

   // Saturating counter registers.
   always_ff @(posedge msoc_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         for (int i = 0; i < 4; i++) stat_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) stat_q[i] <= stat_d[i];
      end
   end

   assign stat_ok   = stat_q[0];
   assign stat_full = stat_q[1];
   assign stat_filt = stat_q[2];
   assign stat_err  = stat_q[3];
`endif

endmodule

// File: tb/tb_eth_rx_ring.sv
// Directed bench for eth_rx_ring with default parameters (NBUF 8, 2 KiB buffers, 64-bit reads).
// Latency: n/a.
// Backpressure: byte driver retries while rx_tready is low, bounded per byte.
module tb_eth_rx_ring;

   localparam int NBUF      = 8;
   localparam int BUF_BYTES = 2048;
   localparam int DATA_W    = 64;
   localparam int AW        = 11;
   localparam logic [47:0] MAC = 48'h001122334455;

   logic              msoc_clk    = 1'b0;
   logic              rst_int_n   = 1'b0;
   logic [7:0]        rx_tdata    = '0;
   logic              rx_tvalid   = 1'b0;
   logic              rx_tlast    = 1'b0;
   logic              rx_tuser    = 1'b0;
   logic              rx_tready;
   logic [47:0]       mac_address = MAC;
   logic              promiscuous = 1'b0;
   logic              irq_en      = 1'b1;
   logic              consume     = 1'b0;
   logic              rd_en       = 1'b0;
   logic [AW-1:0]     rd_addr     = '0;
   logic [DATA_W-1:0] rd_data;
   logic [15:0]       rd_len;
   logic [3:0]        firstbuf;
   logic [3:0]        nextbuf;
   logic              avail;
   logic              eth_irq;

   int errors = 0;
   int checks = 0;

   eth_rx_ring #(
      .NBUF      (NBUF),
      .BUF_BYTES (BUF_BYTES),
      .DATA_W    (DATA_W)
   ) dut (
      .msoc_clk    (msoc_clk),
      .rst_int_n   (rst_int_n),
      .rx_tdata    (rx_tdata),
      .rx_tvalid   (rx_tvalid),
      .rx_tlast    (rx_tlast),
      .rx_tuser    (rx_tuser),
      .rx_tready   (rx_tready),
      .mac_address (mac_address),
      .promiscuous (promiscuous),
      .irq_en      (irq_en),
      .consume     (consume),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_len      (rd_len),
      .firstbuf    (firstbuf),
      .nextbuf     (nextbuf),
      .avail       (avail),
      .eth_irq     (eth_irq)
   );

   always #5 msoc_clk = ~msoc_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Frame byte k: destination MAC MSB first, then k + seed.
   function automatic logic [7:0] fbyte(input logic [47:0] dst, input int k, input logic [7:0] seed);
      if (k < 6) return dst[(5-k)*8 +: 8];
      return 8'(k) + seed;
   endfunction

   task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
      int guard;
      bit done;
      guard = 0;
      done  = 1'b0;
      rx_tvalid = 1'b1;
      rx_tdata  = d;
      rx_tlast  = last;
      rx_tuser  = user;
      while (!done) begin
         @(negedge msoc_clk);
         if (rx_tready) done = 1'b1;
         @(posedge msoc_clk);
         #1;
         guard++;
         if (!done && guard > 8) begin
            chk("tready_timeout", {63'd0, rx_tready}, 64'd1);
            done = 1'b1;
         end
      end
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      rx_tuser  = 1'b0;
   endtask

   // Sends a frame; cons pulses consume during the COMMIT cycle.
   task automatic send_frame(input logic [47:0] dst, input int len, input logic [7:0] seed,
                             input logic user, input logic cons);
      for (int k = 0; k < len; k++) begin
         send_byte(fbyte(dst, k, seed), k == len-1, user && (k == len-1));
      end
      if (cons) chk("commit_tready", {63'd0, rx_tready}, 64'd0);
      consume = cons;
      @(posedge msoc_clk);
      #1;
      consume = 1'b0;
      @(posedge msoc_clk);
      #1;
   endtask

   task automatic rd(input int b, input int w);
      rd_en   = 1'b1;
      rd_addr = {3'(b), 8'(w)};
      @(posedge msoc_clk);
      #1;
      rd_en = 1'b0;
   endtask

   task automatic pop();
      consume = 1'b1;
      @(posedge msoc_clk);
      #1;
      consume = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_nextbuf"},  64'(nextbuf),   64'd0);
      chk({tag, "_firstbuf"}, 64'(firstbuf),  64'd0);
      chk({tag, "_avail"},    64'(avail),     64'd0);
      chk({tag, "_irq"},      64'(eth_irq),   64'd0);
      chk({tag, "_tready"},   64'(rx_tready), 64'd1);
      chk({tag, "_rd_data"},  rd_data,        64'd0);
      chk({tag, "_rd_len"},   64'(rd_len),    64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] exp_w;

      // Reset values while reset is held.
      repeat (3) @(posedge msoc_clk);
      #1;
      chk_reset_outputs("reset");
      rst_int_n = 1'b1;
      @(posedge msoc_clk);
      #1;

      // 1: unicast 64-byte frame to our address.
      send_frame(MAC, 64, 8'h00, 1'b0, 1'b0);
      chk("t1_nextbuf", 64'(nextbuf), 64'd1);
      chk("t1_avail",   64'(avail),   64'd1);
      chk("t1_irq",     64'(eth_irq), 64'd1);
      rd(0, 0);
      chk("t1_w0",  rd_data, 64'h0706554433221100);
      chk("t1_len", 64'(rd_len), 64'd64);
      for (int w = 1; w < 8; w++) begin
         rd(0, w);
         for (int l = 0; l < 8; l++) exp_w[l*8 +: 8] = fbyte(MAC, w*8 + l, 8'h00);
         chk($sformatf("t1_w%0d", w), rd_data, exp_w);
      end
      pop();
      chk("t1_firstbuf", 64'(firstbuf), 64'd1);
      chk("t1_empty",    64'(avail),    64'd0);
      @(posedge msoc_clk);
      #1;
      chk("t1_irq_off", 64'(eth_irq), 64'd0);

      // 2: multicast, broadcast, foreign unicast, promiscuous.
      send_frame(48'h01005E000001, 70, 8'h00, 1'b0, 1'b0);
      chk("t2_mcast", 64'(nextbuf), 64'd2);
      send_frame(48'hFFFFFFFFFFFF, 80, 8'h00, 1'b0, 1'b0);
      chk("t2_bcast", 64'(nextbuf), 64'd3);
      send_frame(48'h020000000001, 64, 8'h00, 1'b0, 1'b0);
      chk("t2_foreign_drop", 64'(nextbuf), 64'd3);
      promiscuous = 1'b1;
      send_frame(48'h020000000001, 65, 8'h00, 1'b0, 1'b0);
      promiscuous = 1'b0;
      chk("t2_promisc", 64'(nextbuf), 64'd4);
      rd(1, 0);
      chk("t2_len1", 64'(rd_len), 64'd70);
      rd(3, 0);
      chk("t2_len3", 64'(rd_len), 64'd65);
      repeat (3) pop();
      chk("t2_firstbuf", 64'(firstbuf), 64'd4);

      // 3: NBUF+1 back-to-back frames, no consume.
      for (int i = 0; i < NBUF + 1; i++) send_frame(MAC, 64, 8'(8'h10 + i), 1'b0, 1'b0);
      chk("t3_nextbuf", 64'(nextbuf), 64'd12);
      chk("t3_count",   64'(4'(nextbuf - firstbuf)), 64'd8);
      rd(4, 1);
      chk("t3_oldest_intact", rd_data, 64'h1F1E1D1C1B1A1918);
      pop();
      send_frame(MAC, 64, 8'h40, 1'b0, 1'b0);
      chk("t3_after_free", 64'(nextbuf), 64'd13);
      repeat (NBUF) pop();
      chk("t3_drained", 64'(avail), 64'd0);

      // 4: tuser error, then good frame in same buffer; runt and oversize drops.
      send_frame(MAC, 64, 8'h50, 1'b1, 1'b0);
      chk("t4_err_drop", 64'(nextbuf), 64'd13);
      send_frame(MAC, 100, 8'h60, 1'b0, 1'b0);
      chk("t4_good", 64'(nextbuf), 64'd14);
      rd(5, 1);
      chk("t4_w1",  rd_data, 64'h6F6E6D6C6B6A6968);
      chk("t4_len", 64'(rd_len), 64'd100);
      send_frame(MAC, 4, 8'h00, 1'b0, 1'b0);
      chk("t4_runt", 64'(nextbuf), 64'd14);
      send_frame(MAC, BUF_BYTES + 2, 8'h00, 1'b0, 1'b0);
      chk("t4_oversize", 64'(nextbuf), 64'd14);
      pop();
      chk("t4_firstbuf", 64'(firstbuf), 64'd14);

      // 5: commit coincident with consume; irq_en follows.
      for (int i = 0; i < 3; i++) send_frame(MAC, 64, 8'(8'h70 + i), 1'b0, 1'b0);
      chk("t5_count3", 64'(4'(nextbuf - firstbuf)), 64'd3);
      send_frame(MAC, 64, 8'h73, 1'b0, 1'b1);
      chk("t5_nextbuf",  64'(nextbuf),  64'd2);
      chk("t5_firstbuf", 64'(firstbuf), 64'd15);
      chk("t5_count",    64'(4'(nextbuf - firstbuf)), 64'd3);
      chk("t5_irq_on",   64'(eth_irq),  64'd1);
      irq_en = 1'b0;
      #1;
      chk("t5_irq_lag", 64'(eth_irq), 64'd1);
      @(posedge msoc_clk);
      #1;
      chk("t5_irq_off", 64'(eth_irq), 64'd0);
      irq_en = 1'b1;
      @(posedge msoc_clk);
      #1;
      chk("t5_irq_back", 64'(eth_irq), 64'd1);

      // 6: reset mid-frame.
      rd(0, 0);
      chk("t6_pre_w0", rd_data, 64'h7978554433221100);
      for (int k = 0; k < 30; k++) send_byte(fbyte(MAC, k, 8'h90), 1'b0, 1'b0);
      rst_int_n = 1'b0;
      #2;
      chk_reset_outputs("t6_rst");
      repeat (2) @(posedge msoc_clk);
      #1;
      rst_int_n = 1'b1;
      @(posedge msoc_clk);
      #1;
      rd(2, 0);
      chk("t6_len_cleared", 64'(rd_len), 64'd0);
      send_frame(MAC, 64, 8'h80, 1'b0, 1'b0);
      chk("t6_nextbuf", 64'(nextbuf), 64'd1);
      rd(0, 1);
      chk("t6_w1",  rd_data, 64'h8F8E8D8C8B8A8988);
      chk("t6_len", 64'(rd_len), 64'd64);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
